// File: rtl/wb2axil_pkg.sv
// Shared types and constants for the Wishbone-to-AXI4-Lite bridge.
package wb2axil_pkg;
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, ACK} state_e;
  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam logic [31:0] ERR_DATA      = 32'hDEADBEEF;
endpackage

// File: rtl/wb2axil_if.sv
// Wishbone slave + AXI4-Lite master signal bundle. The slave modport is the
// bridge's view; the master modport is the surrounding system's view.
interface wb2axil_if #(parameter int AXI_ADDR_W = 16);
  logic                  wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]            wbs_sel_i;
  logic [31:0]           wbs_adr_i, wbs_dat_i;
  logic                  wbs_ack_o;
  logic [31:0]           wbs_dat_o;
  logic [AXI_ADDR_W-1:0] m_awaddr, m_araddr;
  logic                  m_awvalid, m_awready;
  logic [31:0]           m_wdata, m_rdata;
  logic [3:0]            m_wstrb;
  logic                  m_wvalid, m_wready;
  logic [1:0]            m_bresp, m_rresp;
  logic                  m_bvalid, m_bready;
  logic                  m_arvalid, m_arready;
  logic                  m_rvalid, m_rready;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
           m_awready, m_wready, m_bresp, m_bvalid, m_arready,
           m_rdata, m_rresp, m_rvalid,
    output wbs_ack_o, wbs_dat_o, m_awaddr, m_awvalid, m_wdata, m_wstrb,
           m_wvalid, m_bready, m_araddr, m_arvalid, m_rready
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
           m_awready, m_wready, m_bresp, m_bvalid, m_arready,
           m_rdata, m_rresp, m_rvalid,
    input  wbs_ack_o, wbs_dat_o, m_awaddr, m_awvalid, m_wdata, m_wstrb,
           m_wvalid, m_bready, m_araddr, m_arvalid, m_rready
  );
endinterface

// File: rtl/wb2axil_bridge.sv
// Single-outstanding Wishbone slave to AXI4-Lite master bridge.
// Define WB2AXIL_TIMEOUT_EN to abort stalled AXI transfers after TIMEOUT_CYCLES.
module wb2axil_bridge
  import wb2axil_pkg::*;
#(
  parameter int AXI_ADDR_W     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  wb2axil_if.slave bus
);

  state_e                state, state_n, fin_st;
  logic [AXI_ADDR_W-1:0] adr_q;
  logic [31:0]           dat_q;
  logic [3:0]            sel_q;
  logic                  aw_done, w_done;
  logic                  req, aw_hs, w_hs, to_hit;
  logic [35:0]           unused_bits;

  assign req    = bus.wbs_cyc_i && bus.wbs_stb_i;
  assign aw_hs  = bus.m_awvalid && bus.m_awready;
  assign w_hs   = bus.m_wvalid && bus.m_wready;
  // An abandoned Wishbone cycle still drains the AXI side but gets no ack.
  assign fin_st = bus.wbs_cyc_i ? ACK : IDLE;
  assign unused_bits = {bus.wbs_adr_i, bus.m_bresp, bus.m_rresp};

`ifdef WB2AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             busy;

  assign busy   = (state == WADDR) || (state == WRESP) ||
                  (state == RADDR) || (state == RDATA);
  assign to_hit = busy && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i || !busy || state_n != state) to_cnt <= '0;
    else                                        to_cnt <= to_cnt + 1'b1;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (req) state_n = bus.wbs_we_i ? WADDR : RADDR;
      WADDR: if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WRESP;
      WRESP: if (bus.m_bvalid) state_n = fin_st;
      RADDR: if (bus.m_arready) state_n = RDATA;
      RDATA: if (bus.m_rvalid) state_n = fin_st;
      ACK:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (to_hit) state_n = fin_st;
  end

  always_comb begin
    bus.m_awvalid = 1'b0;
    bus.m_wvalid  = 1'b0;
    bus.m_bready  = 1'b0;
    bus.m_arvalid = 1'b0;
    bus.m_rready  = 1'b0;
    bus.wbs_ack_o = 1'b0;
    case (state)
      WADDR: begin
        bus.m_awvalid = !aw_done;
        bus.m_wvalid  = !w_done;
      end
      WRESP:   bus.m_bready  = 1'b1;
      RADDR:   bus.m_arvalid = 1'b1;
      RDATA:   bus.m_rready  = 1'b1;
      ACK:     bus.wbs_ack_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.m_awaddr = adr_q;
  assign bus.m_araddr = adr_q;
  assign bus.m_wdata  = dat_q;
  assign bus.m_wstrb  = sel_q;

  // Payload only loads in IDLE, so it is frozen while any valid is up.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      adr_q         <= '0;
      dat_q         <= '0;
      sel_q         <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      bus.wbs_dat_o <= '0;
    end else begin
      if (state == IDLE && req) begin
        adr_q   <= bus.wbs_adr_i[AXI_ADDR_W-1:0];
        dat_q   <= bus.wbs_dat_i;
        sel_q   <= bus.wbs_sel_i;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (to_hit && (state == RADDR || state == RDATA))
        bus.wbs_dat_o <= ERR_DATA;
      else if (state == RDATA && bus.m_rvalid)
        bus.wbs_dat_o <= (bus.m_rresp == AXI_RESP_OKAY) ? bus.m_rdata : ERR_DATA;
    end
  end

endmodule

// File: tb/tb_wb2axil_bridge.sv
// Scoreboard bench for wb2axil_bridge with a delay-programmable AXI4-Lite slave.
module tb_wb2axil_bridge;
  import wb2axil_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb2axil_if #(.AXI_ADDR_W(16)) bus();

  wb2axil_bridge #(.AXI_ADDR_W(16), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  int n_chk = 0, n_err = 0;
  int cyc_n = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // AXI slave: each ready/valid answers after a programmable number of wait cycles
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  bit ar_never = 0;
  logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;
  logic [31:0] rdata_k = '0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    aw_c  <= (bus.m_awvalid && !bus.m_awready) ? aw_c + 1 : 0;
    w_c   <= (bus.m_wvalid  && !bus.m_wready)  ? w_c + 1  : 0;
    b_c   <= (bus.m_bready  && !bus.m_bvalid)  ? b_c + 1  : 0;
    ar_c  <= (bus.m_arvalid && !bus.m_arready) ? ar_c + 1 : 0;
    r_c   <= (bus.m_rready  && !bus.m_rvalid)  ? r_c + 1  : 0;
  end

  assign bus.m_awready = bus.m_awvalid && (aw_c >= aw_dly);
  assign bus.m_wready  = bus.m_wvalid  && (w_c >= w_dly);
  assign bus.m_bvalid  = bus.m_bready  && (b_c >= b_dly);
  assign bus.m_bresp   = bresp_k;
  assign bus.m_arready = bus.m_arvalid && !ar_never && (ar_c >= ar_dly);
  assign bus.m_rvalid  = bus.m_rready  && (r_c >= r_dly);
  assign bus.m_rdata   = rdata_k;
  assign bus.m_rresp   = rresp_k;

  // Protocol monitor: held valids keep payload, single-beat valids drop after
  // handshake, bready waits for both write handshakes.
  bit mon_en = 1;
  logic rst_seen = 1'b0;
  int viol = 0, ack_cnt = 0;
  logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [15:0] p_awaddr = '0, p_araddr = '0, last_awaddr = '0, last_araddr = '0;
  logic [31:0] p_wdata = '0, last_wdata = '0;
  logic [3:0]  p_wstrb = '0, last_wstrb = '0;
  bit aw_m = 0, w_m = 0;

  always @(posedge clk) rst_seen <= rst_n;

  always @(negedge clk) begin
    if (bus.wbs_ack_o) ack_cnt <= ack_cnt + 1;
    if (!rst_seen) begin
      p_awv <= 0; p_wv <= 0; p_arv <= 0; aw_m <= 0; w_m <= 0;
    end else begin
      if (mon_en) begin
        if (p_awv && !p_awr && (!bus.m_awvalid || bus.m_awaddr !== p_awaddr)) viol <= viol + 1;
        if (p_wv && !p_wr && (!bus.m_wvalid || bus.m_wdata !== p_wdata || bus.m_wstrb !== p_wstrb)) viol <= viol + 1;
        if (p_arv && !p_arr && (!bus.m_arvalid || bus.m_araddr !== p_araddr)) viol <= viol + 1;
        if ((p_awv && p_awr && bus.m_awvalid) || (p_wv && p_wr && bus.m_wvalid) ||
            (p_arv && p_arr && bus.m_arvalid)) viol <= viol + 1;
        if (bus.m_bready && !(aw_m && w_m)) viol <= viol + 1;
      end
      if (bus.m_awvalid && bus.m_awready) begin aw_m <= 1; last_awaddr <= bus.m_awaddr; end
      if (bus.m_wvalid && bus.m_wready) begin
        w_m <= 1; last_wdata <= bus.m_wdata; last_wstrb <= bus.m_wstrb;
      end
      if (bus.m_arvalid && bus.m_arready) last_araddr <= bus.m_araddr;
      if (bus.m_bvalid && bus.m_bready) begin aw_m <= 0; w_m <= 0; end
      p_awv <= bus.m_awvalid; p_awr <= bus.m_awready; p_awaddr <= bus.m_awaddr;
      p_wv  <= bus.m_wvalid;  p_wr  <= bus.m_wready;  p_wdata  <= bus.m_wdata;
      p_wstrb <= bus.m_wstrb;
      p_arv <= bus.m_arvalid; p_arr <= bus.m_arready; p_araddr <= bus.m_araddr;
    end
  end

  // One Wishbone transfer; lat is the ack cycle counted from the capture edge.
  task automatic wb_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] exp_rd, input int budget,
                        input bit exp_ack, input string tag, output int lat);
    int t0, base;
    bit got;
    logic [31:0] e;
    @(negedge clk);
    t0 = cyc_n;
    base = ack_cnt;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    if (exp_ack) exp_q.push_back(exp_rd);
    got = 0;
    lat = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        got = 1;
        lat = cyc_n - t0;
        if (exp_ack && !we) begin
          e = exp_q.pop_front();
          chk({tag, "_data"}, bus.wbs_dat_o, e);
        end else if (exp_ack) begin
          e = exp_q.pop_front();
        end
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    chk({tag, "_acked"}, got, exp_ack);
    if (exp_ack && !got) e = exp_q.pop_front();
    repeat (2) @(negedge clk);
    chk({tag, "_pulses"}, ack_cnt - base, exp_ack ? 1 : 0);
  endtask

  function automatic logic [63:0] outs_vec();
    return {26'd0, bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_arvalid,
            bus.m_rready, bus.wbs_ack_o, bus.wbs_dat_o};
  endfunction

  initial begin
    int lat, base;
    bit seen;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = '0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs_vec(), 64'd0);
    rst_n = 1'b1;

    wb_txn(1, 32'h3000_0010, 32'hA5A5_1234, 4'hF, '0, 20, 1, "wr_basic", lat);
    chk("wr_basic_lat", lat, 3);
    chk("wr_basic_awaddr", last_awaddr, 16'h0010);
    chk("wr_basic_wstrb", last_wstrb, 4'hF);
    chk("wr_basic_wdata", last_wdata, 32'hA5A5_1234);

    rdata_k = 32'h0BAD_F00D;
    wb_txn(0, 32'h0000_0020, '0, 4'hF, 32'h0BAD_F00D, 20, 1, "rd_basic", lat);
    chk("rd_basic_lat", lat, 3);

    ar_dly = 5; rdata_k = 32'h1234_5678;
    wb_txn(0, 32'h1234_0ABC, '0, 4'hF, 32'h1234_5678, 30, 1, "rd_stall", lat);
    chk("rd_stall_lat", lat, 8);
    chk("rd_stall_araddr", last_araddr, 16'h0ABC);
    chk("rd_stall_proto", viol, 0);
    ar_dly = 0;

    aw_dly = 4;
    wb_txn(1, 32'h0000_0044, 32'hCAFE_0001, 4'h3, '0, 30, 1, "wr_skew", lat);
    chk("wr_skew_lat", lat, 7);
    chk("wr_skew_wstrb", last_wstrb, 4'h3);
    chk("wr_skew_proto", viol, 0);
    aw_dly = 0;

    rresp_k = 2'b10; rdata_k = 32'h1111_2222;
    wb_txn(0, 32'h0000_0008, '0, 4'hF, ERR_DATA, 20, 1, "rd_slverr", lat);
    chk("rd_slverr_lat", lat, 3);
    rresp_k = 2'b00;

    bresp_k = 2'b11;
    wb_txn(1, 32'h0000_000C, 32'h0000_0055, 4'h1, '0, 20, 1, "wr_decerr", lat);
    bresp_k = 2'b00;

    b_dly = 3;
    wb_txn(1, 32'h0000_0100, 32'h0F0F_0F0F, 4'hC, '0, 20, 1, "wr_bwait", lat);
    chk("wr_bwait_lat", lat, 6);

    // Master abandons the cycle while the write response is pending.
    b_dly = 6;
    @(negedge clk);
    base = ack_cnt;
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
    bus.wbs_adr_i = 32'h0000_0200; bus.wbs_dat_i = 32'h7777_7777; bus.wbs_sel_i = 4'hF;
    repeat (2) @(negedge clk);
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    repeat (15) @(negedge clk);
    chk("cyc_drop_noack", ack_cnt - base, 0);
    chk("cyc_drop_awaddr", last_awaddr, 16'h0200);

    // Reset while waiting in WRESP.
    b_dly = 50;
    @(negedge clk);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
    bus.wbs_adr_i = 32'h0000_0300; bus.wbs_dat_i = 32'h1; bus.wbs_sel_i = 4'hF;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.m_bready;
    end
    chk("rst_wresp_reached", seen, 1);
    rst_n = 1'b0;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    base = ack_cnt;
    @(negedge clk);
    chk("rst_wresp_outs", outs_vec(), 64'd0);
    rst_n = 1'b1;
    b_dly = 0;
    rdata_k = 32'h55AA_33CC;
    wb_txn(0, 32'h0000_0400, '0, 4'hF, 32'h55AA_33CC, 20, 1, "rd_after_rst", lat);
    chk("rd_after_rst_lat", lat, 3);
    chk("rst_wresp_noack", ack_cnt - base, 1);

    // Slave never accepts the read address.
    ar_never = 1; mon_en = 0;
`ifdef WB2AXIL_TIMEOUT_EN
    wb_txn(0, 32'h0000_0500, '0, 4'hF, ERR_DATA, 30, 1, "rd_timeout", lat);
    chk("rd_timeout_lat", lat, 9);
`else
    wb_txn(0, 32'h0000_0500, '0, 4'hF, '0, 30, 0, "rd_hang", lat);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    ar_never = 0;
    @(negedge clk);
    mon_en = 1;

    rdata_k = 32'hFEED_0042;
    wb_txn(0, 32'h0000_0600, '0, 4'hF, 32'hFEED_0042, 20, 1, "rd_final", lat);
    chk("rd_final_lat", lat, 3);
    chk("final_proto", viol, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wb2axil_bridge.md
WB2AXIL_BRIDGE -- requirements
Module: wb2axil_bridge

Interface
REQ-001 Parameter AXI_ADDR_W, 16, number of low wbs_adr_i bits forwarded to AXI4-Lite address.
REQ-002 Parameter TIMEOUT_CYCLES, 255, AXI wait limit in cycles; used only when WB2AXIL_TIMEOUT_EN is defined.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 wb_clk_i  in  1  sole clock, rising edge.
REQ-005 wb_rst_i  in  1  synchronous reset, active-low.
REQ-006 wbs_cyc_i  in  1  Wishbone cycle valid.
REQ-007 wbs_stb_i  in  1  Wishbone strobe.
REQ-008 wbs_we_i  in  1  1 = write, 0 = read.
REQ-009 wbs_sel_i  in  4  byte lane select.
REQ-010 wbs_adr_i  in  32  byte address.
REQ-011 wbs_dat_i  in  32  write data.
REQ-012 wbs_ack_o  out  1  single-cycle completion pulse.
REQ-013 wbs_dat_o  out  32  read data, registered.
REQ-014 m_awaddr/m_awvalid/m_awready  out/out/in  AXI_ADDR_W/1/1  write address channel.
REQ-015 m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  32/4/1/1  write data channel.
REQ-016 m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  write response channel.
REQ-017 m_araddr/m_arvalid/m_arready  out/out/in  AXI_ADDR_W/1/1  read address channel.
REQ-018 m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  32/2/1/1  read data channel.

Function
REQ-019 States: IDLE, WADDR, WRESP, RADDR, RDATA, ACK; exactly one transaction outstanding.
REQ-020 IDLE, cyc&stb high: capture adr[AXI_ADDR_W-1:0], dat_i, sel; go WADDR if we else RADDR.
REQ-021 WADDR: awvalid and wvalid both rise the cycle after capture; each drops independently after its own valid&ready handshake; go WRESP when both are done.
REQ-022 WRESP: bready=1; on bvalid go ACK. RADDR: arvalid=1 until arready, then RDATA. RDATA: rready=1; on rvalid register rdata into wbs_dat_o, go ACK.
REQ-023 ACK: wbs_ack_o=1 for exactly one cycle; next state IDLE unconditionally.
REQ-024 bresp or rresp != 2'b00: ack still issued; read returns 32'hDEADBEEF.
REQ-025 Minimum latency with zero-wait slave: capture at cycle 0, valid at 1, response at 2, ack at 3.
REQ-026 AXI payloads (addr, wdata, wstrb) stay stable while the matching valid is high.
REQ-027 cyc dropped mid-transaction: AXI transaction runs to completion; ACK state is skipped (IDLE directly); no ack pulse.
REQ-028 Requests are not sampled in ACK or in non-IDLE states; a held stb is serviced only on return to IDLE.

Reset
REQ-029 While wb_rst_i=0 at a clock edge: state IDLE; all valids, readies, and wbs_ack_o = 0; wbs_dat_o = 0; timeout counter = 0. Reset mid-transaction abandons the transaction with no ack.

Configuration
REQ-030 WB2AXIL_TIMEOUT_EN defined: counter runs in WADDR/WRESP/RADDR/RDATA and clears on each state change. At TIMEOUT_CYCLES, deassert all valids/readies, go ACK; reads return 32'hDEADBEEF. Without the macro: no counter; the bridge waits indefinitely.

Structure
REQ-031 Package wb2axil_pkg holds: state enum, AXI_RESP_OKAY=2'b00, ERR_DATA=32'hDEADBEEF.
REQ-032 Single flat module; no sub-module.

Verification
REQ-033 Write adr 0x3000_0010, dat 0xA5A5_1234, sel 0xF, zero-wait slave -> awaddr 0x0010, wstrb 0xF, ack at cycle 3, exactly one pulse.
REQ-034 Read; slave returns rdata 0x1234_5678 after 5-cycle arready stall -> wbs_dat_o 0x1234_5678 with ack; arvalid held stable throughout.
REQ-035 Write; wready 4 cycles before awready -> wvalid drops after its handshake; bready rises only after both handshakes.
REQ-036 Read; rresp 2'b10 -> ack with wbs_dat_o 0xDEADBEEF.
REQ-037 WB2AXIL_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave never asserts arready -> ack 8 cycles after RADDR entry, data 0xDEADBEEF. Without the macro: no ack.
REQ-038 wb_rst_i=0 in WRESP -> next cycle all outputs 0 and state IDLE; a new read then completes normally.
